// File: rtl/decrypt_pipe_unscramble_unshift.sv
`default_nettype none
// ============================================================================
// Module   : decrypt_pipe_unscramble_unshift
// Brief    : Two-stage decrypt pipeline: bit unscramble + classify, then
//            alphabetic un-shift, with valid/ready flow control and a counter.
// Revision : 1.0 - initial release
// ============================================================================
module decrypt_pipe_unscramble_unshift #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       din,
    input  logic             mode,
    input  logic             shift_en,
    input  logic [2:0]       shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       data_out,
    output logic [CNT_W-1:0] char_cnt
);

    // Scramble map: the encrypter builds s[i] = p[PERM_i]; element i sits at bits [3i+:3].
    localparam logic [23:0] c_PERM = {3'd6, 3'd3, 3'd4, 3'd1, 3'd7, 3'd0, 3'd5, 3'd2};
    localparam logic [7:0]  c_UPPER_BASE = 8'd65;
    localparam logic [7:0]  c_LOWER_BASE = 8'd97;

    logic       r_s1_valid;
    logic [7:0] r_s1_u;
    logic       r_s1_upper;
    logic       r_s1_lower;
    logic       r_s1_mode;
    logic       r_s1_shift_en;
    logic [2:0] r_s1_shift_amt;
    logic       r_s2_valid;

    logic       w_s2_load;
    logic       w_s1_adv;
    logic [7:0] w_unscr;
    logic [7:0] w_u;
    logic [7:0] w_base;
    logic [4:0] w_idx;
    logic [4:0] w_amt;
    logic [4:0] w_res;
    logic [7:0] w_s2_data;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_unscramble
            assign w_unscr[c_PERM[3*i +: 3]] = din[i];
        end
    endgenerate

    assign w_u = mode ? din : w_unscr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_u         <= w_u;
                r_s1_upper     <= (w_u >= 8'd65) && (w_u <= 8'd90);
                r_s1_lower     <= (w_u >= 8'd97) && (w_u <= 8'd122);
                r_s1_mode      <= mode;
                r_s1_shift_en  <= shift_en;
                r_s1_shift_amt <= shift_amt;
            end
        end
    end

    // Index never exceeds 25 and the wrap branch only runs when idx < amt,
    // so idx + (26 - amt) stays within 5 bits.
    assign w_base = r_s1_upper ? c_UPPER_BASE : c_LOWER_BASE;
    assign w_idx  = 5'(r_s1_u - w_base);
    assign w_amt  = {2'b00, r_s1_shift_amt};
    assign w_res  = (w_idx >= w_amt) ? (w_idx - w_amt) : (w_idx + (5'd26 - w_amt));

    always_comb begin
        w_s2_data = r_s1_u;
        if (!r_s1_mode && r_s1_shift_en && (r_s1_upper || r_s1_lower))
            w_s2_data = w_base + {3'b000, w_res};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            data_out   <= 8'h00;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid)
                data_out <= w_s2_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            char_cnt <= '0;
        else if (r_s2_valid && out_ready)
            char_cnt <= char_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_decrypt_pipe_unscramble_unshift.sv
`default_nettype none
// ============================================================================
// Module   : tb_decrypt_pipe_unscramble_unshift
// Brief    : Directed self-checking bench for decrypt_pipe_unscramble_unshift.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decrypt_pipe_unscramble_unshift;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       din;
    logic             mode;
    logic             shift_en;
    logic [2:0]       shift_amt;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       data_out;
    logic [CNT_W-1:0] char_cnt;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    decrypt_pipe_unscramble_unshift #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .mode      (mode),
        .shift_en  (shift_en),
        .shift_amt (shift_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .char_cnt  (char_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int perm_idx(input int i);
        case (i)
            0: return 2;
            1: return 5;
            2: return 0;
            3: return 7;
            4: return 1;
            5: return 4;
            6: return 3;
            default: return 6;
        endcase
    endfunction

    // Encrypt-side scramble: s[i] = p[PERM_i]
    function automatic logic [7:0] perm(input logic [7:0] p);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) s[i] = p[perm_idx(i)];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_single(input string tag, input logic m, input logic en,
                               input logic [2:0] amt, input logic [7:0] d,
                               input logic [7:0] exp);
        in_valid  = 1'b1;
        mode      = m;
        shift_en  = en;
        shift_amt = amt;
        din       = d;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        din      = 8'hxx;
        check({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, data_out}, {24'd0, exp});
        tick();
        exp_cnt = exp_cnt + 1'b1;
        check({tag, "_cnt"}, {28'd0, char_cnt}, {28'd0, exp_cnt});
    endtask

    logic [7:0] bp_din  [8];
    logic       bp_mode [8];
    logic [7:0] bp_exp  [8];
    int         in_idx;
    int         out_idx;
    int         cyc;
    bit         saw_stall;
    logic       s_in_ready, s_out_valid;
    logic [7:0] s_data;

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = 8'h00; mode = 1'b0;
        shift_en = 1'b0; shift_amt = 3'd0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_char_cnt", {28'd0, char_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send_single("G_sh3",   1'b0, 1'b1, 3'd3, perm(8'h47), 8'h44);
        send_single("b_sh5",   1'b0, 1'b1, 3'd5, perm(8'h62), 8'h77);
        send_single("A_sh7",   1'b0, 1'b1, 3'd7, perm(8'h41), 8'h54);
        send_single("Z_sh7",   1'b0, 1'b1, 3'd7, perm(8'h5A), 8'h53);
        send_single("a_sh1",   1'b0, 1'b1, 3'd1, perm(8'h61), 8'h7A);
        send_single("z_sh0",   1'b0, 1'b1, 3'd0, perm(8'h7A), 8'h7A);
        send_single("space",   1'b0, 1'b1, 3'd3, perm(8'h20), 8'h20);
        send_single("at",      1'b0, 1'b1, 3'd2, perm(8'h40), 8'h40);
        send_single("lbrk",    1'b0, 1'b1, 3'd2, perm(8'h5B), 8'h5B);
        send_single("btick",   1'b0, 1'b1, 3'd2, perm(8'h60), 8'h60);
        send_single("lbrace",  1'b0, 1'b1, 3'd2, perm(8'h7B), 8'h7B);
        send_single("noshift", 1'b0, 1'b0, 3'd4, perm(8'h78), 8'h78);
        send_single("bypass9C",1'b1, 1'b1, 3'd3, 8'h9C, 8'h9C);
        send_single("bypassG", 1'b1, 1'b1, 3'd3, 8'h47, 8'h47);

        // Backpressure stream: alternating decrypt/bypass beats
        rst = 1'b1; tick(); rst = 1'b0; exp_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            bp_mode[i] = i[0];
            bp_exp[i]  = 8'h30 + 8'(i * 7);
            bp_din[i]  = bp_mode[i] ? bp_exp[i] : perm(bp_exp[i]);
        end
        in_idx = 0; out_idx = 0; cyc = 0; saw_stall = 1'b0;
        shift_en = 1'b1; shift_amt = 3'd0;
        while ((out_idx < 8) && (cyc < 40)) begin
            in_valid  = (in_idx < 8);
            din       = (in_idx < 8) ? bp_din[in_idx] : 8'h00;
            mode      = (in_idx < 8) ? bp_mode[in_idx] : 1'b0;
            out_ready = !((cyc >= 3) && (cyc <= 5));
            #2;
            s_in_ready  = in_ready;
            s_out_valid = out_valid;
            s_data      = data_out;
            if (in_valid && !s_in_ready) saw_stall = 1'b1;
            tick();
            if (in_valid && s_in_ready) in_idx++;
            if (s_out_valid && out_ready) begin
                check($sformatf("bp_out%0d", out_idx), {24'd0, s_data}, {24'd0, bp_exp[out_idx]});
                out_idx++;
                exp_cnt = exp_cnt + 1'b1;
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_all_out", out_idx, 32'd8);
        check("bp_in_ready_drop", {31'd0, saw_stall}, 32'd1);
        tick();
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);
        check("bp_char_cnt", {28'd0, char_cnt}, 32'd8);

        // Reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1; mode = 1'b1; shift_en = 1'b0;
        din = 8'hA1; tick();
        din = 8'hA2; tick();
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_char_cnt", {28'd0, char_cnt}, 32'd0);
        check("mid_rst_data_out", {24'd0, data_out}, 32'h00);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);
        exp_cnt = '0;
        send_single("post_rst", 1'b0, 1'b1, 3'd3, perm(8'h47), 8'h44);

        // 16 more transfers on a 4-bit counter: 17 total wraps to 1
        out_ready = 1'b1; mode = 1'b1; shift_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            din = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        check("cnt_wrap", {28'd0, char_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decrypt_pipe_unscramble_unshift.md
DECRYPT_PIPE_UNSCRAMBLE_UNSHIFT -- requirements
Module: decrypt_pipe_unscramble_unshift

Interface
REQ-001 Parameter CNT_W, default 16, width of the decrypted-character counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  din/side inputs valid this cycle.
REQ-005 in_ready  output  1  block accepts the input beat this cycle.
REQ-006 din  input  8  scrambled ciphertext byte.
REQ-007 mode  input  1  0 = decrypt, 1 = bypass; sampled with din.
REQ-008 shift_en  input  1  enables alphabetic un-shift; sampled with din.
REQ-009 shift_amt  input  3  alphabetic shift to undo, 0-7; sampled with din.
REQ-010 out_valid  output  1  data_out holds a result.
REQ-011 out_ready  input  1  downstream accepts data_out this cycle.
REQ-012 data_out  output  8  recovered plaintext byte.
REQ-013 char_cnt  output  CNT_W  count of beats delivered on the output.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 The datapath SHALL be two register stages, S1 (unscramble/classify) and S2 (un-shift/output), each with a valid bit.
REQ-016 S2 SHALL load when !S2.valid || out_ready; S1 SHALL advance when !S1.valid || S2 loads; in_ready SHALL equal the S1 advance condition, combinationally.
REQ-017 Latency SHALL be 2 cycles from input transfer to out_valid with no stall; sustained throughput SHALL be 1 beat/cycle with out_ready held high.
REQ-018 Stalled stages SHALL hold data, valid and sampled side inputs unchanged; no beat SHALL be dropped or duplicated.
REQ-019 S1, mode=0: SHALL store u where u[`PERM_i] = din[i] for i=0..7 (exact inverse of the encrypt scramble, `PERM_* from encrypt_config).
REQ-020 S1, mode=1: SHALL store u = din unchanged.
REQ-021 S1 SHALL classify u: upper if 65<=u<=90, lower if 97<=u<=122, else non-alpha; class, mode, shift_en, shift_amt SHALL be registered with u.
REQ-022 S2, mode=0, shift_en=1, alpha: index i = u-65 (upper) or u-97 (lower); result index SHALL be i-shift_amt if i>=shift_amt, else i+26-shift_amt; output SHALL be base+result in the same case.
REQ-023 S2, non-alpha, shift_en=0, or mode=1: data_out SHALL equal u.
REQ-024 Un-shift arithmetic SHALL use at least 5-bit unsigned intermediates; no other wrap than REQ-022.
REQ-025 char_cnt SHALL increment by 1 on every output transfer, wrapping from 2^CNT_W-1 to 0; it SHALL NOT count input transfers or bypass distinctions.
REQ-026 Simultaneous output transfer and S1->S2 move in one cycle SHALL be supported (full pipeline, no bubble).
REQ-027 in_valid=1 while in_ready=0 SHALL NOT alter state; the source holds the beat.

Reset
REQ-028 On rst=1 at a clock edge: S1.valid=0, S2.valid=0, out_valid=0, data_out=8'h00, char_cnt=0; in_ready SHALL be 1 in the cycle after reset.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no output transfer SHALL occur from pre-reset data.
REQ-030 Stage data registers other than data_out need no reset value; only valid bits gate behaviour.

Verification
REQ-031 mode=0, shift_en=1, shift_amt=3, din=PERM(8'h47 'G'), out_ready=1 -> data_out=8'h44 'D', out_valid exactly 2 cycles after transfer, char_cnt=1.
REQ-032 Wrap: mode=0, shift_en=1, shift_amt=5, din=PERM(8'h62 'b') -> data_out=8'h77 'w'; din=PERM(8'h41 'A'), shift_amt=7 -> 8'h54 'T'.
REQ-033 Non-alpha/bypass: mode=0, shift_en=1, din=PERM(8'h20) -> 8'h20; mode=1, din=8'h9C -> 8'h9C with 2-cycle latency.
REQ-034 Backpressure: stream 8 beats back-to-back, out_ready low for 3 cycles mid-stream -> in_ready drops after S1/S2 fill, all 8 outputs in order, no loss/duplication, char_cnt=8.
REQ-035 Reset mid-stream with S1 and S2 full -> next cycle out_valid=0, char_cnt=0, data_out=8'h00; first post-reset beat emerges after 2 cycles.
REQ-036 Counter wrap with CNT_W=4: 17 output transfers -> char_cnt=1.
